// File: rtl/gp_data_upsizer_pkg.sv
// rtl/gp_data_upsizer_pkg.sv - shared helpers for the gp_data_upsizer narrow-to-wide converter
package gp_data_upsizer_pkg;

  localparam int KEEP_MAX = 64;

  // Beat-counter width; never narrower than one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  // Thermometer mask with slots 0..cnt set.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned cnt);
    return (KEEP_MAX'(2) << cnt) - KEEP_MAX'(1);
  endfunction

endpackage

// File: rtl/gp_upsizer_pack.sv
// rtl/gp_upsizer_pack.sv - assembly register and slot-write decode for gp_data_upsizer
module gp_upsizer_pack #(
  parameter int DATA_WIDTH_IN = 8,
  parameter int RATIO         = 4,
  parameter int CNT_WIDTH     = 2
) (
  input  logic                             clk_i,
  input  logic [CNT_WIDTH-1:0]             cnt_i,
  input  logic [DATA_WIDTH_IN-1:0]         beat_i,
  input  logic                             wr_en_i,
  output logic [DATA_WIDTH_IN*RATIO-1:0]   word_o
);

  logic [RATIO-2:0][DATA_WIDTH_IN-1:0] r_slots;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < RATIO - 1; k++) begin
      if (wr_en_i && (cnt_i == CNT_WIDTH'(k))) begin
        r_slots[k] <= beat_i;
      end
    end
  end

  // Word as it would close on this beat: earlier slots, current beat, zeros above.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (CNT_WIDTH'(k) < cnt_i) begin
        word_o[k*DATA_WIDTH_IN +: DATA_WIDTH_IN] = r_slots[k];
      end else if (CNT_WIDTH'(k) == cnt_i) begin
        word_o[k*DATA_WIDTH_IN +: DATA_WIDTH_IN] = beat_i;
      end
    end
    if (cnt_i == CNT_WIDTH'(RATIO - 1)) begin
      word_o[(RATIO-1)*DATA_WIDTH_IN +: DATA_WIDTH_IN] = beat_i;
    end
  end

endmodule

// File: rtl/gp_data_upsizer.sv
// rtl/gp_data_upsizer.sv - packs RATIO narrow beats into one registered wide word
// Optional early-close/keep/last sideband enabled by GP_DATA_UPSIZER_LAST_EN.
module gp_data_upsizer
  import gp_data_upsizer_pkg::*;
#(
  parameter int DATA_WIDTH_IN = 8,
  parameter int RATIO         = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  output logic                             rx_ready_o,
  input  logic                             rx_valid_i,
  input  logic [DATA_WIDTH_IN-1:0]         rx_data_i,
`ifdef GP_DATA_UPSIZER_LAST_EN
  input  logic                             rx_last_i,
  output logic                             tx_last_o,
  output logic [RATIO-1:0]                 tx_keep_o,
`endif
  input  logic                             tx_ready_i,
  output logic                             tx_valid_o,
  output logic [DATA_WIDTH_IN*RATIO-1:0]   tx_data_o
);

  localparam int DATA_WIDTH_OUT = DATA_WIDTH_IN * RATIO;
  localparam int CNT_WIDTH      = cnt_width(RATIO);

  if (RATIO < 2) begin : g_ratio_check
    $error("gp_data_upsizer: RATIO must be >= 2");
  end

  logic [CNT_WIDTH-1:0]      r_cnt;
  logic                      r_tx_valid;
  logic [DATA_WIDTH_OUT-1:0] r_tx_data;
  logic                      w_close;
  logic                      w_rx_xfer;
  logic                      w_tx_xfer;
  logic [DATA_WIDTH_OUT-1:0] w_word;

`ifdef GP_DATA_UPSIZER_LAST_EN
  assign w_close = (r_cnt == CNT_WIDTH'(RATIO - 1)) | rx_last_i;
`else
  assign w_close = (r_cnt == CNT_WIDTH'(RATIO - 1));
`endif

  // Only the closing beat waits for the output register to drain.
  assign rx_ready_o = ~w_close | ~r_tx_valid | tx_ready_i;
  assign w_rx_xfer  = rx_valid_i & rx_ready_o;
  assign w_tx_xfer  = r_tx_valid & tx_ready_i;

  gp_upsizer_pack #(
    .DATA_WIDTH_IN (DATA_WIDTH_IN),
    .RATIO         (RATIO),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_pack (
    .clk_i   (clk_i),
    .cnt_i   (r_cnt),
    .beat_i  (rx_data_i),
    .wr_en_i (w_rx_xfer & ~w_close),
    .word_o  (w_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      if (w_rx_xfer) begin
        r_cnt <= w_close ? '0 : r_cnt + CNT_WIDTH'(1);
      end
      if (w_rx_xfer && w_close) begin
        r_tx_valid <= 1'b1;
      end else if (w_tx_xfer) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rx_xfer && w_close) begin
      r_tx_data <= w_word;
    end
  end

`ifdef GP_DATA_UPSIZER_LAST_EN
  logic             r_tx_last;
  logic [RATIO-1:0] r_tx_keep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_last <= 1'b0;
      r_tx_keep <= '0;
    end else if (w_rx_xfer && w_close) begin
      r_tx_last <= rx_last_i;
      r_tx_keep <= RATIO'(keep_mask(32'(r_cnt)));
    end
  end

  assign tx_last_o = r_tx_last;
  assign tx_keep_o = r_tx_keep;
`endif

  assign tx_valid_o = r_tx_valid;
  assign tx_data_o  = r_tx_data;

endmodule
